video_dram_timing_sequencer: RTL and testbench

Generates the RAS, CAS and WE strobes, the row/column address-multiplexer select and the refresh row address for the video board's dynamic RAM array. It arbitrates between video fetch, CPU access and periodic refresh. It sits directly upstream of the DRAM control and address-decoding stage, which gates these strobes with the bank selects into the per-bank active-low RAS/CAS/WE lines. It also drives the CPU WAIT_AL line.

---
 rtl/video_dram_timing_sequencer.sv | 171 +++++++++++++++++
 tb/tb_video_dram_timing_sequencer.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_dram_timing_sequencer.sv
// Video DRAM timing sequencer: arbitrates video fetch, CPU access and refresh,
// and sequences RAS/CAS/WE/MUX strobes. All outputs are registered.
// Grant at edge T gives RAS in T+1. The CPU is held off through WAIT_AL until
// its access has completed. A granted cycle always runs to completion.
module video_dram_timing_sequencer #(
  parameter int CAS_CYCLES       = 2,
  parameter int PRE_CYCLES       = 2,
  parameter int RFSH_RAS_CYCLES  = 4,
  parameter int REFRESH_INTERVAL = 64,
  parameter int ROW_BITS         = 7
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                VREQ,
  input  logic                CPU_REQ,
  input  logic                CPU_WR,
  output logic                RAS,
  output logic                CAS,
  output logic                WE,
  output logic                MUX,
  output logic                REFRESH,
  output logic [ROW_BITS-1:0] RFSH_ADDR,
  output logic                DLATCH,
  output logic                VACK,
  output logic                WAIT_AL,
  output logic [1:0]          OWNER
);

  localparam int MAX_AB = (CAS_CYCLES > PRE_CYCLES) ? CAS_CYCLES : PRE_CYCLES;
  localparam int MAXC   = (MAX_AB > RFSH_RAS_CYCLES) ? MAX_AB : RFSH_RAS_CYCLES;
  localparam int CW     = $clog2(MAXC + 1);
  localparam int TW     = $clog2(REFRESH_INTERVAL);

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_VID  = 2'b01;
  localparam logic [1:0] OWN_CPU  = 2'b10;
  localparam logic [1:0] OWN_REF  = 2'b11;

  typedef enum logic [2:0] {IDLE, ROW, COL, CASP, PRE, RFSH} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;        // cycles remaining in the current multi-cycle state
  logic [TW-1:0]   timer;
  logic [1:0]      pend;       // outstanding refreshes, saturates at 2
  logic            cpu_done;   // current CPU request already served
  logic            is_wr;      // CPU_WR captured at grant

  logic            arb_point;
  logic            expire;
  logic            cpu_end;
  logic            cpu_done_nxt;
  logic            grant_ref;
  logic [1:0]      arb;

  // Arbitration decision and handshake next-state, evaluated every cycle.
  always_comb begin
    arb_point = (state == IDLE) || (state == PRE && cnt == '0);
    expire    = (timer == '0);
    cpu_end   = (state == CASP) && (cnt == '0) && (OWNER == OWN_CPU);
    if (pend == 2'd2)                  arb = OWN_REF;
    else if (VREQ)                     arb = OWN_VID;
    else if (pend == 2'd1)             arb = OWN_REF;
    else if (CPU_REQ && !cpu_done)     arb = OWN_CPU;
    else                               arb = OWN_NONE;
    grant_ref    = arb_point && (arb == OWN_REF);
    // Dropping CPU_REQ re-arms the CPU; completion latches until then.
    cpu_done_nxt = CPU_REQ && (cpu_done || cpu_end);
  end

  // Sequencer FSM, refresh timer and all registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      cnt       <= '0;
      timer     <= TW'(REFRESH_INTERVAL - 1);
      pend      <= 2'd0;
      cpu_done  <= 1'b0;
      is_wr     <= 1'b0;
      RAS       <= 1'b0;
      CAS       <= 1'b0;
      WE        <= 1'b0;
      MUX       <= 1'b0;
      REFRESH   <= 1'b0;
      DLATCH    <= 1'b0;
      VACK      <= 1'b0;
      WAIT_AL   <= 1'b1;
      RFSH_ADDR <= '0;
      OWNER     <= OWN_NONE;
    end else begin
      timer <= expire ? TW'(REFRESH_INTERVAL - 1) : timer - 1'b1;
      // Expiry and refresh grant together cancel out.
      if (expire && !grant_ref && pend != 2'd2) pend <= pend + 2'd1;
      else if (!expire && grant_ref)            pend <= pend - 2'd1;

      cpu_done <= cpu_done_nxt;
      WAIT_AL  <= !(CPU_REQ && !cpu_done_nxt);
      DLATCH   <= 1'b0;
      VACK     <= 1'b0;

      if (arb_point) begin
        if (state == PRE && OWNER == OWN_REF) RFSH_ADDR <= RFSH_ADDR + 1'b1;
        OWNER   <= arb;
        REFRESH <= (arb == OWN_REF);
        CAS     <= 1'b0;
        WE      <= 1'b0;
        MUX     <= 1'b0;
        is_wr   <= (arb == OWN_CPU) && CPU_WR;
        case (arb)
          OWN_REF: begin
            state <= RFSH;
            cnt   <= CW'(RFSH_RAS_CYCLES - 1);
            RAS   <= 1'b1;
          end
          OWN_VID, OWN_CPU: begin
            state <= ROW;
            RAS   <= 1'b1;
          end
          default: begin
            state <= IDLE;
            RAS   <= 1'b0;
          end
        endcase
      end else begin
        case (state)
          ROW: begin
            state <= COL;
            MUX   <= 1'b1;
            WE    <= is_wr;
          end
          COL: begin
            state <= CASP;
            cnt   <= CW'(CAS_CYCLES - 1);
            CAS   <= 1'b1;
            if (CAS_CYCLES == 1) begin
              DLATCH <= !is_wr;
              VACK   <= (OWNER == OWN_VID);
            end
          end
          CASP: begin
            if (cnt == '0) begin
              state <= PRE;
              cnt   <= CW'(PRE_CYCLES - 1);
              RAS   <= 1'b0;
              CAS   <= 1'b0;
              WE    <= 1'b0;
              MUX   <= 1'b0;
            end else begin
              cnt <= cnt - 1'b1;
              if (cnt == CW'(1)) begin
                DLATCH <= !is_wr;
                VACK   <= (OWNER == OWN_VID);
              end
            end
          end
          RFSH: begin
            if (cnt == '0) begin
              state <= PRE;
              cnt   <= CW'(PRE_CYCLES - 1);
              RAS   <= 1'b0;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          PRE:     cnt   <= cnt - 1'b1;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_video_dram_timing_sequencer.sv
module tb_video_dram_timing_sequencer;

  localparam int CASN = 2;
  localparam int PREN = 2;
  localparam int RRN  = 4;
  localparam int RI   = 64;
  localparam int RB   = 7;

  logic          CLK = 1'b0;
  logic          RESET, VREQ, CPU_REQ, CPU_WR;
  logic          RAS, CAS, WE, MUX, REFRESH, DLATCH, VACK, WAIT_AL;
  logic [RB-1:0] RFSH_ADDR;
  logic [1:0]    OWNER;

  video_dram_timing_sequencer #(
    .CAS_CYCLES(CASN), .PRE_CYCLES(PREN), .RFSH_RAS_CYCLES(RRN),
    .REFRESH_INTERVAL(RI), .ROW_BITS(RB)
  ) dut (
    .CLK(CLK), .RESET(RESET), .VREQ(VREQ), .CPU_REQ(CPU_REQ), .CPU_WR(CPU_WR),
    .RAS(RAS), .CAS(CAS), .WE(WE), .MUX(MUX), .REFRESH(REFRESH),
    .RFSH_ADDR(RFSH_ADDR), .DLATCH(DLATCH), .VACK(VACK), .WAIT_AL(WAIT_AL),
    .OWNER(OWNER)
  );

  always #5 CLK = ~CLK;

  // Reference model: each granted cycle is expanded into a list of per-cycle
  // output words; arbitration happens whenever that list runs dry.
  typedef struct packed {
    logic ras, cas, we, mux, refresh, dlatch, vack;
    logic [1:0] owner;
  } ow_t;
  typedef struct packed {
    ow_t  o;
    logic last_ref;
    logic cpu_end;
  } ent_t;

  ent_t q[$];
  int   k, pend, m_addr;
  bit   m_cpu_done;
  ow_t  exp_o;
  logic exp_wait;
  int   checks = 0, failures = 0, cyc = 0;

  task automatic push_access(input logic [1:0] own, input logic wr);
    ent_t e;
    e = '0; e.o.ras = 1; e.o.owner = own;
    q.push_back(e);
    e.o.mux = 1; e.o.we = wr;
    q.push_back(e);
    for (int i = 0; i < CASN; i++) begin
      e.o.cas    = 1;
      e.o.dlatch = (i == CASN - 1) && !wr;
      e.o.vack   = (i == CASN - 1) && (own == 2'b01);
      e.cpu_end  = (i == CASN - 1) && (own == 2'b10);
      q.push_back(e);
    end
    for (int i = 0; i < PREN; i++) begin
      e = '0; e.o.owner = own;
      q.push_back(e);
    end
  endtask

  task automatic push_refresh();
    ent_t e;
    for (int i = 0; i < RRN; i++) begin
      e = '0; e.o.ras = 1; e.o.refresh = 1; e.o.owner = 2'b11;
      q.push_back(e);
    end
    for (int i = 0; i < PREN; i++) begin
      e = '0; e.o.refresh = 1; e.o.owner = 2'b11; e.last_ref = (i == PREN - 1);
      q.push_back(e);
    end
  endtask

  task automatic model_edge();
    ent_t e;
    bit done_set, expire, gref;
    if (RESET) begin
      q.delete(); k = 0; pend = 0; m_cpu_done = 0; m_addr = 0;
      exp_o = '0; exp_wait = 1'b1;
    end else begin
      done_set = 0; gref = 0;
      k++;
      expire = (k % RI == 0);
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.last_ref) m_addr = (m_addr + 1) % (1 << RB);
        if (e.cpu_end) done_set = 1;
      end
      if (q.size() == 0) begin
        if (pend == 2) begin push_refresh(); gref = 1; end
        else if (VREQ) push_access(2'b01, 1'b0);
        else if (pend == 1) begin push_refresh(); gref = 1; end
        else if (CPU_REQ && !m_cpu_done) push_access(2'b10, CPU_WR);
      end
      if (!CPU_REQ) m_cpu_done = 0;
      else if (done_set) m_cpu_done = 1;
      pend = pend + (expire ? 1 : 0) - (gref ? 1 : 0);
      if (pend > 2) pend = 2;
      exp_o    = (q.size() > 0) ? q[0].o : '0;
      exp_wait = !(CPU_REQ && !m_cpu_done);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    cyc++;
  endtask

  function automatic logic [16:0] obs_vec();
    return {RAS, CAS, WE, MUX, REFRESH, DLATCH, VACK, OWNER, WAIT_AL, RFSH_ADDR};
  endfunction

  function automatic logic [16:0] exp_vec();
    logic [RB-1:0] a;
    a = m_addr[RB-1:0];
    return {exp_o, exp_wait, a};
  endfunction

  task automatic reset_dut();
    RESET = 1; VREQ = 0; CPU_REQ = 0; CPU_WR = 0;
    step(); step();
    RESET = 0;
  endtask

  task automatic test_reset();
    RESET = 1; VREQ = 0; CPU_REQ = 1; CPU_WR = 0;
    step(); step();
    checks++;
    if (obs_vec() !== exp_vec()) begin
      failures++; $display("FAIL reset_model got=%h exp=%h", obs_vec(), exp_vec());
    end
    checks++;
    if ({RAS, CAS, WE, MUX, REFRESH, DLATCH, VACK, WAIT_AL, OWNER, RFSH_ADDR} !== {7'b0, 1'b1, 2'b00, 7'd0}) begin
      failures++; $display("FAIL reset_values got=%b%b%b%b%b%b%b w=%b o=%b a=%0d exp=0000000 w=1 o=00 a=0",
                           RAS, CAS, WE, MUX, REFRESH, DLATCH, VACK, WAIT_AL, OWNER, RFSH_ADDR);
    end
    RESET = 0; CPU_REQ = 0;
  endtask

  task automatic test_cpu_read();
    int rows;
    reset_dut();
    rows = 0;
    CPU_REQ = 1; CPU_WR = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL cpu_read_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
      if (RAS && !MUX && OWNER == 2'b10) rows++;
      if (c == 1) begin
        checks++;
        if ({RAS, WAIT_AL, OWNER} !== 4'b1010) begin
          failures++; $display("FAIL cpu_read_grant got=%b exp=1010", {RAS, WAIT_AL, OWNER});
        end
      end
      if (c == 4) begin
        checks++;
        if (DLATCH !== 1'b1) begin
          failures++; $display("FAIL cpu_read_dlatch got=%b exp=1", DLATCH);
        end
      end
      if (c == 5) begin
        checks++;
        if (WAIT_AL !== 1'b1) begin
          failures++; $display("FAIL cpu_read_wait_release got=%b exp=1", WAIT_AL);
        end
      end
    end
    checks++;
    if (rows != 1) begin
      failures++; $display("FAIL cpu_read_single_access got=%0d exp=1", rows);
    end
    CPU_REQ = 0;
    step();
  endtask

  task automatic test_video_cpu();
    int first_ras, second_ras;
    logic prev_ras;
    reset_dut();
    first_ras = 0; second_ras = 0; prev_ras = 0;
    VREQ = 1; CPU_REQ = 1; CPU_WR = 0;
    for (int c = 1; c <= 16; c++) begin
      step();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL video_cpu_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
      if (RAS && !prev_ras) begin
        if (first_ras == 0) first_ras = c;
        else if (second_ras == 0) second_ras = c;
      end
      prev_ras = RAS;
      if (c == 1) begin
        checks++;
        if (OWNER !== 2'b01) begin
          failures++; $display("FAIL video_first_owner got=%b exp=01", OWNER);
        end
      end
      if (VACK === 1'b1 && VREQ) begin
        checks++;
        if (c != 4) begin
          failures++; $display("FAIL video_vack_cycle got=%0d exp=4", c);
        end
        VREQ = 0;
      end
      if (c == 7) begin
        checks++;
        if (OWNER !== 2'b10) begin
          failures++; $display("FAIL cpu_after_video_owner got=%b exp=10", OWNER);
        end
      end
    end
    checks++;
    if (second_ras - first_ras != 6) begin
      failures++; $display("FAIL ras_spacing got=%0d exp=6", second_ras - first_ras);
    end
    VREQ = 0; CPU_REQ = 0;
    step();
  endtask

  task automatic test_cpu_write();
    int we_n, we_cas_n;
    reset_dut();
    we_n = 0; we_cas_n = 0;
    CPU_REQ = 1; CPU_WR = 1;
    for (int c = 1; c <= 12; c++) begin
      step();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL cpu_write_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
      if (WE) we_n++;
      if (WE && CAS) we_cas_n++;
      CPU_WR = 1'($urandom);
    end
    checks++;
    if (we_n != 3 || we_cas_n != 2) begin
      failures++; $display("FAIL cpu_write_we_width got=%0d/%0d exp=3/2", we_n, we_cas_n);
    end
    CPU_REQ = 0;
    step();
  endtask

  task automatic test_refresh();
    int rf_n, ras_n, cas_n;
    bit wrap_seen;
    logic [RB-1:0] prev_addr;
    reset_dut();
    rf_n = 0; ras_n = 0; cas_n = 0; wrap_seen = 0; prev_addr = '0;
    for (int c = 1; c <= 80; c++) begin
      step();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL refresh_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
      if (REFRESH) rf_n++;
      if (RAS) ras_n++;
      if (CAS) cas_n++;
    end
    checks++;
    if (rf_n != 6 || ras_n != 4 || cas_n != 0 || RFSH_ADDR !== 7'd1) begin
      failures++; $display("FAIL refresh_single got=rf%0d ras%0d cas%0d a%0d exp=rf6 ras4 cas0 a1",
                           rf_n, ras_n, cas_n, RFSH_ADDR);
    end
    prev_addr = RFSH_ADDR;
    for (int c = 81; c <= 8300 && !wrap_seen; c++) begin
      step();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL refresh_wrap_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
      if (prev_addr == 7'd127 && RFSH_ADDR == 7'd0) wrap_seen = 1;
      prev_addr = RFSH_ADDR;
    end
    checks++;
    if (!wrap_seen) begin
      failures++; $display("FAIL refresh_addr_wrap got=no_wrap exp=127->0");
    end
  endtask

  task automatic test_vreq_hold();
    int ref_starts, preempt;
    logic [1:0] prev_owner;
    reset_dut();
    ref_starts = 0; preempt = 0; prev_owner = 2'b00;
    VREQ = 1;
    for (int c = 1; c <= 200; c++) begin
      step();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL vreq_hold_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
      if (OWNER == 2'b11 && prev_owner != 2'b11) begin
        ref_starts++;
        if (prev_owner == 2'b01) preempt++;
      end
      prev_owner = OWNER;
    end
    checks++;
    if (ref_starts < 1 || preempt < 1) begin
      failures++; $display("FAIL vreq_hold_refresh_preempt got=%0d/%0d exp=>=1/>=1", ref_starts, preempt);
    end
    VREQ = 0;
    step();
  endtask

  task automatic test_reset_mid();
    reset_dut();
    CPU_REQ = 1; CPU_WR = 1;
    step(); step(); step();
    checks++;
    if ({CAS, WE} !== 2'b11) begin
      failures++; $display("FAIL reset_mid_setup got=%b exp=11", {CAS, WE});
    end
    RESET = 1;
    step();
    checks++;
    if ({RAS, CAS, WE, WAIT_AL, OWNER, RFSH_ADDR} !== {3'b000, 1'b1, 2'b00, 7'd0}) begin
      failures++; $display("FAIL reset_mid got=%b exp=%b", {RAS, CAS, WE, WAIT_AL, OWNER, RFSH_ADDR},
                           {3'b000, 1'b1, 2'b00, 7'd0});
    end
    checks++;
    if (obs_vec() !== exp_vec()) begin
      failures++; $display("FAIL reset_mid_model got=%h exp=%h", obs_vec(), exp_vec());
    end
    RESET = 0; CPU_REQ = 0;
    step();
  endtask

  task automatic test_random();
    reset_dut();
    for (int c = 1; c <= 3000; c++) begin
      if (VREQ) begin if ($urandom_range(2) == 0) VREQ = 0; end
      else if ($urandom_range(7) == 0) VREQ = 1;
      if (CPU_REQ) begin if (m_cpu_done && $urandom_range(1) == 0) CPU_REQ = 0; end
      else if ($urandom_range(5) == 0) CPU_REQ = 1;
      CPU_WR = 1'($urandom);
      step();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL random_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
    end
    VREQ = 0; CPU_REQ = 0;
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_video_cpu();
    test_cpu_write();
    test_refresh();
    test_vreq_hold();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
